reorder_buffer: RTL and testbench

- 16-entry in-order retirement buffer of the dual-issue out-of-order core.
- Sits downstream of rename/dispatch, which writes robDispatchStruct, and downstream of the complete stage, which sends up to 3 completeStruct per cycle.
- Allocates ROB numbers, records completions and retires up to 2 instructions per cycle in program order.
- Retire outputs drive the architectural commit: register/memory commit and return of rd_old to the rename free pool.

---
 rtl/reorder_buffer.sv | 162 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry in-order retirement buffer, dual dispatch, 3 completion ports, dual retire
// Struct ports are flattened; multi-slot fields pack slot/port 0 in the low bits.
module reorder_buffer #(
  parameter int ROB_SIZE_BITS = 4,
  parameter int NUM_CPL       = 3,
  parameter int PC_W          = 32,
  parameter int REG_W         = 5,
  parameter int CTRL_W        = 4,
  parameter int DATA_W        = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             dispatch_valid1,
  input  logic                             dispatch_valid2,
  input  logic [REG_W-1:0]                 dispatch_dest_reg1,
  input  logic [REG_W-1:0]                 dispatch_dest_reg2,
  input  logic [REG_W-1:0]                 dispatch_dest_reg_old1,
  input  logic [REG_W-1:0]                 dispatch_dest_reg_old2,
  input  logic [CTRL_W-1:0]                dispatch_control1,
  input  logic [CTRL_W-1:0]                dispatch_control2,
  input  logic [PC_W-1:0]                  dispatch_pc1,
  input  logic [PC_W-1:0]                  dispatch_pc2,
  input  logic [NUM_CPL-1:0]               complete_valid,
  input  logic [NUM_CPL*ROB_SIZE_BITS-1:0] complete_rob_num,
  input  logic [NUM_CPL*DATA_W-1:0]        complete_result,
  input  logic [NUM_CPL*DATA_W-1:0]        complete_mem_data,
  output logic [ROB_SIZE_BITS-1:0]         rob_num1,
  output logic [ROB_SIZE_BITS-1:0]         rob_num2,
  output logic                             dispatch_stall,
  output logic [1:0]                       retire_valid,
  output logic [2*PC_W-1:0]                retire_pc,
  output logic [2*REG_W-1:0]               retire_rd,
  output logic [2*REG_W-1:0]               retire_rd_old,
  output logic [2*DATA_W-1:0]              retire_result,
  output logic [2*DATA_W-1:0]              retire_mem_data,
  output logic [2*CTRL_W-1:0]              retire_control,
  output logic                             rob_empty,
  output logic [ROB_SIZE_BITS:0]           rob_count
);
  localparam int DEPTH = 1 << ROB_SIZE_BITS;
  localparam logic [ROB_SIZE_BITS:0] STALL_AT = (ROB_SIZE_BITS+1)'(DEPTH - 2);
  typedef logic [ROB_SIZE_BITS-1:0] idx_t;

  logic [DEPTH-1:0]   valid_q, valid_d, complete_q, complete_d, cpl_we;
  logic [PC_W-1:0]    pc_q     [DEPTH];
  logic [REG_W-1:0]   rd_q     [DEPTH];
  logic [REG_W-1:0]   rd_old_q [DEPTH];
  logic [CTRL_W-1:0]  ctrl_q   [DEPTH];
  logic [DATA_W-1:0]  result_q [DEPTH];
  logic [DATA_W-1:0]  mem_q    [DEPTH];
  logic [DATA_W-1:0]  cpl_result [DEPTH];
  logic [DATA_W-1:0]  cpl_mem    [DEPTH];
  idx_t               head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [ROB_SIZE_BITS:0] count_q, count_d;
  logic               disp_we1, disp_we2;
  logic [1:0]         num_disp, num_ret;

  assign head1          = head_q + 1'b1;
  assign tail1          = tail_q + 1'b1;
  assign rob_num1       = tail_q;
  assign rob_num2       = tail1;
  assign rob_count      = count_q;
  assign rob_empty      = (count_q == '0);
  assign dispatch_stall = (count_q > STALL_AT);
  assign disp_we1       = dispatch_valid1 & ~dispatch_stall;
  assign disp_we2       = disp_we1 & dispatch_valid2;
  assign num_disp       = {1'b0, disp_we1} + {1'b0, disp_we2};

  // Retire looks only at registered completion state: no same-cycle bypass.
  assign retire_valid[0] = valid_q[head_q] & complete_q[head_q];
  assign retire_valid[1] = retire_valid[0] & valid_q[head1] & complete_q[head1];
  assign num_ret         = {1'b0, retire_valid[0]} + {1'b0, retire_valid[1]};

  assign retire_pc       = {pc_q[head1],     pc_q[head_q]};
  assign retire_rd       = {rd_q[head1],     rd_q[head_q]};
  assign retire_rd_old   = {rd_old_q[head1], rd_old_q[head_q]};
  assign retire_control  = {ctrl_q[head1],   ctrl_q[head_q]};
  assign retire_result   = {result_q[head1], result_q[head_q]};
  assign retire_mem_data = {mem_q[head1],    mem_q[head_q]};

  // Ports scanned high to low so the lowest-index port overrides on a shared robNum.
  always_comb begin
    cpl_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cpl_result[i] = '0;
      cpl_mem[i]    = '0;
      for (int p = NUM_CPL - 1; p >= 0; p--) begin
        if (complete_valid[p] &&
            complete_rob_num[p*ROB_SIZE_BITS +: ROB_SIZE_BITS] == idx_t'(i) &&
            valid_q[i] &&
            !(disp_we1 && tail_q == idx_t'(i)) &&
            !(disp_we2 && tail1 == idx_t'(i))) begin
          cpl_we[i]     = 1'b1;
          cpl_result[i] = complete_result[p*DATA_W +: DATA_W];
          cpl_mem[i]    = complete_mem_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q | cpl_we;
    if (retire_valid[0]) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
    end
    if (retire_valid[1]) begin
      valid_d[head1]    = 1'b0;
      complete_d[head1] = 1'b0;
    end
    if (disp_we1) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
    end
    if (disp_we2) begin
      valid_d[tail1]    = 1'b1;
      complete_d[tail1] = 1'b0;
    end
    head_d  = head_q + idx_t'(num_ret);
    tail_d  = tail_q + idx_t'(num_disp);
    count_d = count_q + (ROB_SIZE_BITS+1)'(num_disp) - (ROB_SIZE_BITS+1)'(num_ret);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload needs no reset; valid/complete gate every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cpl_we[i]) begin
        result_q[i] <= cpl_result[i];
        mem_q[i]    <= cpl_mem[i];
      end
    end
    if (disp_we1) begin
      pc_q[tail_q]     <= dispatch_pc1;
      rd_q[tail_q]     <= dispatch_dest_reg1;
      rd_old_q[tail_q] <= dispatch_dest_reg_old1;
      ctrl_q[tail_q]   <= dispatch_control1;
    end
    if (disp_we2) begin
      pc_q[tail1]     <= dispatch_pc2;
      rd_q[tail1]     <= dispatch_dest_reg2;
      rd_old_q[tail1] <= dispatch_dest_reg_old2;
      ctrl_q[tail1]   <= dispatch_control2;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - randomized and directed bench for reorder_buffer against a queue model
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_valid1, dispatch_valid2;
  logic [4:0]  dispatch_dest_reg1, dispatch_dest_reg2, dispatch_dest_reg_old1, dispatch_dest_reg_old2;
  logic [3:0]  dispatch_control1, dispatch_control2;
  logic [31:0] dispatch_pc1, dispatch_pc2;
  logic [2:0]  complete_valid;
  logic [11:0] complete_rob_num;
  logic [95:0] complete_result, complete_mem_data;
  logic [3:0]  rob_num1, rob_num2;
  logic        dispatch_stall, rob_empty;
  logic [1:0]  retire_valid;
  logic [63:0] retire_pc, retire_result, retire_mem_data;
  logic [9:0]  retire_rd, retire_rd_old;
  logic [7:0]  retire_control;
  logic [4:0]  rob_count;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .dispatch_valid1(dispatch_valid1), .dispatch_valid2(dispatch_valid2),
    .dispatch_dest_reg1(dispatch_dest_reg1), .dispatch_dest_reg2(dispatch_dest_reg2),
    .dispatch_dest_reg_old1(dispatch_dest_reg_old1), .dispatch_dest_reg_old2(dispatch_dest_reg_old2),
    .dispatch_control1(dispatch_control1), .dispatch_control2(dispatch_control2),
    .dispatch_pc1(dispatch_pc1), .dispatch_pc2(dispatch_pc2),
    .complete_valid(complete_valid), .complete_rob_num(complete_rob_num),
    .complete_result(complete_result), .complete_mem_data(complete_mem_data),
    .rob_num1(rob_num1), .rob_num2(rob_num2), .dispatch_stall(dispatch_stall),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_rd(retire_rd),
    .retire_rd_old(retire_rd_old), .retire_result(retire_result),
    .retire_mem_data(retire_mem_data), .retire_control(retire_control),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  typedef struct {
    logic [3:0]  num;
    logic [31:0] pc;
    logic [4:0]  rd, rd_old;
    logic [3:0]  ctrl;
    logic        done;
    logic [31:0] res, mem;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] mtail;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    dispatch_valid1 = 0; dispatch_valid2 = 0;
    dispatch_pc1 = 0; dispatch_pc2 = 0;
    dispatch_dest_reg1 = 0; dispatch_dest_reg2 = 0;
    dispatch_dest_reg_old1 = 0; dispatch_dest_reg_old2 = 0;
    dispatch_control1 = 0; dispatch_control2 = 0;
    complete_valid = 0; complete_rob_num = 0;
    complete_result = 0; complete_mem_data = 0;
  endtask

  task automatic disp(input logic v1, input logic v2, input logic [31:0] pc1, input logic [31:0] pc2);
    dispatch_valid1 = v1; dispatch_valid2 = v2;
    dispatch_pc1 = pc1; dispatch_pc2 = pc2;
    dispatch_dest_reg1 = 5'($urandom); dispatch_dest_reg2 = 5'($urandom);
    dispatch_dest_reg_old1 = 5'($urandom); dispatch_dest_reg_old2 = 5'($urandom);
    dispatch_control1 = 4'($urandom); dispatch_control2 = 4'($urandom);
  endtask

  task automatic cpl(input int p, input logic [3:0] n, input logic [31:0] r);
    complete_valid[p] = 1'b1;
    complete_rob_num[p*4 +: 4] = n;
    complete_result[p*32 +: 32] = r;
    complete_mem_data[p*32 +: 32] = $urandom;
  endtask

  function automatic logic [1:0] exp_rv();
    logic [1:0] rv;
    rv[0] = (mq.size() > 0) && mq[0].done;
    rv[1] = rv[0] && (mq.size() > 1) && mq[1].done;
    return rv;
  endfunction

  task automatic check_outputs();
    logic [1:0] rv;
    logic [3:0] t1;
    rv = exp_rv();
    t1 = mtail + 4'd1;
    chk("count", rob_count, mq.size());
    chk("empty", rob_empty, mq.size() == 0);
    chk("stall", dispatch_stall, mq.size() > 14);
    chk("num1", rob_num1, mtail);
    chk("num2", rob_num2, t1);
    chk("retire_valid", retire_valid, rv);
    for (int s = 0; s < 2; s++) begin
      if (rv[s]) begin
        chk("ret_pc", retire_pc[s*32 +: 32], mq[s].pc);
        chk("ret_rd", retire_rd[s*5 +: 5], mq[s].rd);
        chk("ret_rd_old", retire_rd_old[s*5 +: 5], mq[s].rd_old);
        chk("ret_ctrl", retire_control[s*4 +: 4], mq[s].ctrl);
        chk("ret_result", retire_result[s*32 +: 32], mq[s].res);
        chk("ret_mem", retire_mem_data[s*32 +: 32], mq[s].mem);
      end
    end
  endtask

  // Model of one clock edge: complete (lowest port first), retire, then dispatch.
  task automatic model_step();
    bit         taken [16];
    logic [3:0] n;
    logic [1:0] rv;
    bit         stall;
    ent_t       e;
    rv = exp_rv();
    stall = mq.size() > 14;
    for (int i = 0; i < 16; i++) taken[i] = 0;
    for (int p = 0; p < 3; p++) begin
      if (complete_valid[p]) begin
        n = complete_rob_num[p*4 +: 4];
        if (!taken[n]) begin
          taken[n] = 1;
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].num == n) begin
              mq[k].done = 1;
              mq[k].res = complete_result[p*32 +: 32];
              mq[k].mem = complete_mem_data[p*32 +: 32];
            end
          end
        end
      end
    end
    if (rv[0]) void'(mq.pop_front());
    if (rv[1]) void'(mq.pop_front());
    if (!stall && dispatch_valid1) begin
      e = '{num: mtail, pc: dispatch_pc1, rd: dispatch_dest_reg1, rd_old: dispatch_dest_reg_old1,
            ctrl: dispatch_control1, done: 0, res: 0, mem: 0};
      mq.push_back(e);
      mtail = mtail + 4'd1;
      if (dispatch_valid2) begin
        e = '{num: mtail, pc: dispatch_pc2, rd: dispatch_dest_reg2, rd_old: dispatch_dest_reg_old2,
              ctrl: dispatch_control2, done: 0, res: 0, mem: 0};
        mq.push_back(e);
        mtail = mtail + 4'd1;
      end
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    reset = 1;
    mq.delete();
    mtail = 0;
    @(negedge clk);
    reset = 0;
  endtask

  // Completes the oldest outstanding entries until the buffer is empty (bounded).
  task automatic drain();
    int p;
    for (int c = 0; c < 200 && mq.size() > 0; c++) begin
      p = 0;
      for (int k = 0; k < mq.size() && p < 3; k++) begin
        if (!mq[k].done) begin
          cpl(p, mq[k].num, $urandom);
          p++;
        end
      end
      cycle();
    end
    chk("drain_empty", rob_empty, 1);
  endtask

  initial begin
    bit saw14, wrap_ok;
    int r;
    idle();
    reset = 1;
    mq.delete();
    mtail = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_count", rob_count, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_rv", retire_valid, 0);
    chk("rst_stall", dispatch_stall, 0);
    chk("rst_num1", rob_num1, 0);
    chk("rst_num2", rob_num2, 1);

    // Async reset mid-cycle with 5 entries held, two of them ready to retire.
    disp(1, 1, 32'h10, 32'h14); cycle();
    disp(1, 1, 32'h18, 32'h1c); cycle();
    disp(1, 0, 32'h20, 0);      cycle();
    cpl(0, 4'd0, 32'h5); cpl(1, 4'd1, 32'h6); cycle();
    chk("amid_pre_count", rob_count, 5);
    #2 reset = 1;
    #1;
    chk("amid_count", rob_count, 0);
    chk("amid_empty", rob_empty, 1);
    chk("amid_rv", retire_valid, 0);
    mq.delete();
    mtail = 0;
    @(negedge clk);
    reset = 0;
    chk("amid_num1", rob_num1, 0);

    // Basic flow: out-of-order completion, in-order dual retire.
    disp(1, 1, 32'h100, 32'h104);
    chk("bf_num1", rob_num1, 0);
    chk("bf_num2", rob_num2, 1);
    cycle();
    cpl(0, 4'd1, 32'h22); cycle();
    cpl(2, 4'd0, 32'h11);
    chk("bf_c2_rv", retire_valid, 2'b00);
    cycle();
    chk("bf_c3_rv", retire_valid, 2'b11);
    chk("bf_c3_res0", retire_result[31:0], 32'h11);
    chk("bf_c3_res1", retire_result[63:32], 32'h22);
    cycle();
    chk("bf_c4_empty", rob_empty, 1);

    // Stall at 15 entries; dispatch while stalled is dropped.
    repeat (15) begin disp(1, 0, $urandom, 0); cycle(); end
    chk("st_stall", dispatch_stall, 1);
    disp(1, 1, $urandom, $urandom); cycle();
    chk("st_count15", rob_count, 15);
    cpl(0, mq[0].num, $urandom); cycle();
    chk("st_rv", retire_valid, 2'b01);
    cycle();
    chk("st_count14", rob_count, 14);
    chk("st_nostall", dispatch_stall, 0);
    drain();

    // Wrap-around with dispatch/complete/retire pairs.
    if (mtail[0]) begin disp(1, 0, $urandom, 0); cycle(); drain(); end
    saw14 = 0; wrap_ok = 0;
    for (int i = 0; i < 40; i++) begin
      disp(1, 1, 32'h1000 + 8 * i, 32'h1004 + 8 * i);
      if (saw14 && rob_num1 == 4'd0 && rob_num2 == 4'd1) wrap_ok = 1;
      saw14 = (rob_num1 == 4'd14) && (rob_num2 == 4'd15);
      cycle();
      chk("wr_le2", rob_count <= 2, 1);
      cpl(0, mq[0].num, $urandom); cpl(1, mq[1].num, $urandom); cycle();
      cycle();
    end
    chk("wr_seq", wrap_ok, 1);

    // Completion conflicts: port0 beats port2 on rob 3; rob 9 is not allocated.
    do_reset();
    disp(1, 1, 32'h200, 32'h204); cycle();
    disp(1, 1, 32'h208, 32'h20c); cycle();
    cpl(0, 4'd0, 32'h1); cpl(1, 4'd1, 32'h2); cpl(2, 4'd2, 32'h3); cycle();
    cpl(0, 4'd3, 32'hAAAA); cpl(2, 4'd3, 32'hBBBB); cpl(1, 4'd9, 32'hCCCC); cycle();
    chk("cf_rv", retire_valid, 2'b11);
    chk("cf_res", retire_result[63:32], 32'hAAAA);
    cycle();
    chk("cf_empty", rob_empty, 1);
    chk("cf_rv_none", retire_valid, 2'b00);

    // Partial retire.
    disp(1, 1, 32'h300, 32'h304); cycle();
    cpl(0, 4'd4, 32'h44); cycle();
    chk("pr_rv", retire_valid, 2'b01);
    cycle();
    chk("pr_count", rob_count, 1);
    chk("pr_head_pc_gone", rob_num1, 4'd6);
    cpl(0, 4'd5, 32'h55); cpl(1, 4'd6, 32'h66); cycle();
    chk("pr_rv2", retire_valid, 2'b01);
    cycle();
    chk("pr_empty", rob_empty, 1);

    // Randomized traffic, including illegal valid2-only and stalled dispatch.
    repeat (400) begin
      r = $urandom_range(0, 7);
      disp(r < 4, (r < 2) || (r == 7), $urandom, $urandom);
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            cpl(p, mq[$urandom_range(0, mq.size() - 1)].num, $urandom);
          else
            cpl(p, 4'($urandom), $urandom);
        end
      end
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
